// File: rtl/snn_ctrl_if.sv
// Configuration port of the spiking-network inference sequencer.
// One beat carries a single synaptic weight bit addressed to one neuron.
//   cfg_valid_i  host -> block   beat valid
//   cfg_ready_o  block -> host   block accepts beats (only while idle)
//   cfg_addr_i   host -> block   neuron index of the weight bit
//   cfg_data_i   host -> block   weight bit value
// master: the host / config logic side; slave: snn_ctrl.
interface snn_ctrl_if #(
  parameter int ADDR_W = 8
) ();
  logic              cfg_valid_i;
  logic              cfg_ready_o;
  logic [ADDR_W-1:0] cfg_addr_i;
  logic              cfg_data_i;

  modport master (
    output cfg_valid_i,
    output cfg_addr_i,
    output cfg_data_i,
    input  cfg_ready_o
  );

  modport slave (
    input  cfg_valid_i,
    input  cfg_addr_i,
    input  cfg_data_i,
    output cfg_ready_o
  );
endinterface

// File: rtl/snn_ctrl.sv
// snn_ctrl: inference sequencer for the spiking network.
// Weight bits arrive over the cfg interface into a shadow register while idle
// and are committed to the neuron array when a window starts. Each window is:
// one CLEAR cycle (nrst_o pulse), WINDOW_CYCLES RUN cycles (run_o high, spikes
// counted with saturation) and one DONE cycle (done_o pulse, count_o updated).
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   cfg              snn_ctrl_if.slave weight configuration port
//   start_i          begin a window (sampled in IDLE only)
//   stop_i           abort (honoured in CLEAR, RUN, DONE)
//   spike_i          winner-selection spike output
//   syn_weights_o    committed weights, one bit per neuron
//   nrst_o, run_o    neuron reset pulse, network enable
//   count_o, done_o  spike count of last completed window, update pulse
//   busy_o, err_o    not idle, sticky out-of-range config address
// Optional feature macro: SNN_CTRL_AUTORESTART_EN -- DONE goes back to CLEAR
// so windows run back-to-back with the same committed weights.
module snn_ctrl #(
  parameter int NUM_NODES     = 1,
  parameter int ADDR_W        = 8,
  parameter int WINDOW_CYCLES = 1200000,
  parameter int CNT_W         = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  snn_ctrl_if.slave            cfg,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 spike_i,
  output logic [NUM_NODES-1:0] syn_weights_o,
  output logic                 nrst_o,
  output logic                 run_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int                WIN_W    = $clog2(WINDOW_CYCLES + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t               state;
  logic                 ready;
  logic [NUM_NODES-1:0] shadow;
  logic [NUM_NODES-1:0] shadow_nxt;
  logic [CNT_W-1:0]     spk_cnt;
  logic [WIN_W-1:0]     win_cnt;
  logic [ADDR_W-1:0]    addr;
  logic                 beat;
  logic                 in_range;
  logic                 beat_ok;
  logic                 beat_bad;

  // Saturating increment: the spike counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic s);
    if (s && (c != {CNT_W{1'b1}}))
      return c + 1'b1;
    return c;
  endfunction

  // Moore outputs of a state, packed as {ready, busy, nrst, run, done}.
  // They are loaded on the same edge as the state so they stay registered.
  function automatic logic [4:0] dec(input state_t s);
    case (s)
      IDLE:    return 5'b10000;
      CLEAR:   return 5'b01100;
      RUN:     return 5'b01010;
      DONE:    return 5'b01001;
      default: return 5'b10000;
    endcase
  endfunction

  assign cfg.cfg_ready_o = ready;
  assign addr     = cfg.cfg_addr_i;
  assign beat     = cfg.cfg_valid_i & ready;
  assign in_range = 32'(addr) < 32'(NUM_NODES);
  assign beat_ok  = beat & in_range;
  assign beat_bad = beat & ~in_range;

  // Shadow including this cycle's beat, so a beat accepted together with
  // start_i is part of the committed weights.
  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < NUM_NODES; i++) begin
      if (beat_ok && (32'(addr) == 32'(i)))
        shadow_nxt[i] = cfg.cfg_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      {ready, busy_o, nrst_o, run_o, done_o} <= dec(IDLE);
      shadow        <= '0;
      syn_weights_o <= '0;
      count_o       <= '0;
      spk_cnt       <= '0;
      win_cnt       <= '0;
      err_o         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          shadow <= shadow_nxt;
          if (start_i) begin
            state         <= CLEAR;
            {ready, busy_o, nrst_o, run_o, done_o} <= dec(CLEAR);
            syn_weights_o <= shadow_nxt;
            spk_cnt       <= '0;
            win_cnt       <= '0;
            err_o         <= beat_bad;
          end else begin
            err_o <= err_o | beat_bad;
          end
        end
        CLEAR: begin
          if (stop_i) begin
            state <= IDLE;
            {ready, busy_o, nrst_o, run_o, done_o} <= dec(IDLE);
          end else begin
            state <= RUN;
            {ready, busy_o, nrst_o, run_o, done_o} <= dec(RUN);
          end
        end
        RUN: begin
          // stop_i outranks window expiry: count_o is left untouched.
          if (stop_i) begin
            state <= IDLE;
            {ready, busy_o, nrst_o, run_o, done_o} <= dec(IDLE);
          end else begin
            spk_cnt <= sat_inc(spk_cnt, spike_i);
            win_cnt <= win_cnt + 1'b1;
            if (win_cnt == WIN_LAST) begin
              // Include a spike arriving in the final RUN cycle.
              count_o <= sat_inc(spk_cnt, spike_i);
              state   <= DONE;
              {ready, busy_o, nrst_o, run_o, done_o} <= dec(DONE);
            end
          end
        end
        DONE: begin
          if (stop_i) begin
            state <= IDLE;
            {ready, busy_o, nrst_o, run_o, done_o} <= dec(IDLE);
          end else begin
`ifdef SNN_CTRL_AUTORESTART_EN
            state   <= CLEAR;
            {ready, busy_o, nrst_o, run_o, done_o} <= dec(CLEAR);
            spk_cnt <= '0;
            win_cnt <= '0;
`else
            state <= IDLE;
            {ready, busy_o, nrst_o, run_o, done_o} <= dec(IDLE);
`endif
          end
        end
        default: begin
          state <= IDLE;
          {ready, busy_o, nrst_o, run_o, done_o} <= dec(IDLE);
        end
      endcase
    end
  end

endmodule
